// File: rtl/my_andornot_bist.sv
// Self-test sequencer for a 4-input AND-OR-INVERT cell: sweeps all 16 vectors and counts mismatches.
// Optional build macro ANDORNOT_STOP_ON_FAIL_EN ends the run at the first mismatch.
module my_andornot_bist #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail_vec
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_APPLY = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // The counter counts down to zero inside WAIT, so it is loaded with one less than the window.
    localparam logic [3:0] SETTLE_INIT = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    function automatic logic golden_y(input logic [3:0] v);
        return ~((v[3] & v[2]) | (v[1] & v[0]));
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  vec_q, vec_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [4:0]  err_q, err_d;
    logic [3:0]  ffv_q, ffv_d;
    logic        mismatch_s;
    logic        finish_s;
    logic [4:0]  err_inc_s;

    assign mismatch_s = (state_q == S_CHECK) && (y != golden_y(vec_q));
    assign err_inc_s  = (err_q == 5'd16) ? 5'd16 : (err_q + 5'd1);
`ifdef ANDORNOT_STOP_ON_FAIL_EN
    assign finish_s   = (idx_q == 4'hF) || mismatch_s;
`else
    assign finish_s   = (idx_q == 4'hF);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_APPLY;
                else       state_d = state_q;
            end
            S_APPLY: begin
                if (SETTLE_CYCLES == 0) state_d = S_CHECK;
                else                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_CHECK;
                else               state_d = S_WAIT;
            end
            S_CHECK: begin
                if (finish_s) state_d = S_DONE;
                else          state_d = S_APPLY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and status next values
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        vec_d  = vec_q;
        busy_d = busy_q;
        done_d = done_q;
        pass_d = pass_q;
        err_d  = err_q;
        ffv_d  = ffv_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    idx_d  = 4'd0;
                    err_d  = 5'd0;
                    ffv_d  = 4'd0;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    pass_d = 1'b0;
                end else begin
                    idx_d  = idx_q;
                end
            end
            S_APPLY: begin
                vec_d = idx_q;
                cnt_d = SETTLE_INIT;
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               cnt_d = cnt_q;
            end
            S_CHECK: begin
                if (mismatch_s) begin
                    err_d = err_inc_s;
                    if (err_q == 5'd0) ffv_d = idx_q;
                    else               ffv_d = ffv_q;
                end else begin
                    err_d = err_q;
                end
                if (finish_s) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (err_d == 5'd0);
                end else begin
                    idx_d  = idx_q + 4'd1;
                end
            end
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                pass_d = 1'b0;
            end
        endcase
    end

    // Datapath and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= 4'd0;
            cnt_q  <= 4'd0;
            vec_q  <= 4'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            err_q  <= 5'd0;
            ffv_q  <= 4'd0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            vec_q  <= vec_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
            err_q  <= err_d;
            ffv_q  <= ffv_d;
        end
    end

    assign {a, b, c, d}   = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_my_andornot_bist.sv
// Directed bench for my_andornot_bist: good cell, stuck-at faults, mid-run reset and ignored restart.
module tb_my_andornot_bist;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       a, b, c, d, y;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic [3:0] first_fail_vec;
    int         cell_mode = 0;   // 0 good, 1 stuck-at-0, 2 stuck-at-1
    int         passed = 0;
    int         total = 0;
    int         cycles;

    my_andornot_bist dut (
        .clk(clk), .rst(rst), .start(start),
        .a(a), .b(b), .c(c), .d(d), .y(y),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail_vec(first_fail_vec)
    );

    always #5 clk = ~clk;

    assign y = (cell_mode == 1) ? 1'b0 :
               (cell_mode == 2) ? 1'b1 : ~((a & b) | (c & d));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Accept a start pulse, then count edges until done rises (bounded).
    task automatic run_to_done(input int repulse_at);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        cycles = 0;
        while (!done && cycles < 300) begin
            if (cycles == repulse_at) begin
                @(negedge clk); start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cycles++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_abcd", {a, b, c, d}, 0);
        check("rst_err", err_count, 0);
        check("rst_ffv", first_fail_vec, 0);
        @(negedge clk); rst = 1'b0;

        // Good cell
        cell_mode = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("run_pass_low", pass, 0);
        cycles = 0;
        while (!done && cycles < 300) begin
            @(posedge clk); #1; cycles++;
        end
`ifdef ANDORNOT_STOP_ON_FAIL_EN
        check("good_cycles", cycles, 64);
`else
        check("good_cycles", cycles, 64);
`endif
        check("good_pass", pass, 1);
        check("good_err", err_count, 0);
        check("good_ffv", first_fail_vec, 0);
        check("good_busy", busy, 0);
        check("good_abcd_hold", {a, b, c, d}, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        check("done_holds", done, 1);

        // Stuck-at-0
        cell_mode = 1;
        run_to_done(-1);
`ifdef ANDORNOT_STOP_ON_FAIL_EN
        check("sa0_cycles", cycles, 4);
        check("sa0_err", err_count, 1);
`else
        check("sa0_cycles", cycles, 64);
        check("sa0_err", err_count, 9);
`endif
        check("sa0_ffv", first_fail_vec, 4'h0);
        check("sa0_pass", pass, 0);

        // Stuck-at-1
        cell_mode = 2;
        run_to_done(-1);
`ifdef ANDORNOT_STOP_ON_FAIL_EN
        check("sa1_cycles", cycles, 16);
        check("sa1_err", err_count, 1);
`else
        check("sa1_cycles", cycles, 64);
        check("sa1_err", err_count, 7);
`endif
        check("sa1_ffv", first_fail_vec, 4'h3);
        check("sa1_pass", pass, 0);
        check("sa1_done", done, 1);

        // Mid-run reset at cycle 20
        cell_mode = 1;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_abcd", {a, b, c, d}, 0);
        check("abort_err", err_count, 0);
        @(negedge clk); rst = 1'b0;
        cell_mode = 0;
        run_to_done(-1);
        check("after_rst_cycles", cycles, 64);
        check("after_rst_pass", pass, 1);

        // Restart request while busy is ignored
        run_to_done(10);
        check("repulse_cycles", cycles, 64);
        check("repulse_pass", pass, 1);
        check("repulse_err", err_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
